config_bus_writer: RTL and testbench
====================================

// Module: config_bus_writer
// PURPOSE
//  Master/transmitter side of the shared configuration bus (config_addr 32b + config_data 512b).
//  The PS writes 32-bit words into a 16-word staging buffer, then writes a target configuration address to commit.
//  The block snapshots the buffer, drives address+data for HOLD_CYCLES cycles, and then returns the bus to IDLE_ADDR.
//  It feeds all config-bus receivers in parallel, e.g. axis routing and biquad/gain blocks.
// PARAMETERS
//  DATA_WORDS   16    32-bit words in config_data (512/32); fixed at 16
//  HOLD_CYCLES  2     cycles config_addr/config_data stay asserted per commit (>=1)
//  IDLE_ADDR    0     address driven when no transaction is active; never used by any receiver
//  COUNT_WIDTH  16    width of commit_count
// PORTS
//  a_clk         in   1    system clock (125 MHz)
//  a_rst         in   1    synchronous reset, active high
//  s_wr_en       in   1    one-cycle write strobe from the PS register port
//  s_wr_addr     in   5    0..15 staging word; 16 commit; 17 clear staging; 18 clear overrun
//  s_wr_data     in   32   write data (for commit: the target config address)
//  config_addr   out  32   config bus address, registered
//  config_data   out  512  config bus data, registered; word k = bits [32k+31:32k]
//  busy          out  1    high while state != IDLE
//  commit_count  out  CW   accepted commits, wraps modulo 2^COUNT_WIDTH
//  overrun       out  1    sticky: commit rejected because busy
// BEHAVIOUR
//  Reset (synchronous, any state, takes priority over all other inputs):
//   config_addr=IDLE_ADDR; config_data=0; staging=0; state=IDLE; busy=0; commit_count=0; overrun=0.
//   Reset during HOLD aborts the transaction on the same edge.
//  Staging write (s_wr_addr<16): staging[s_wr_addr] <= s_wr_data. Allowed in every state.
//   It never alters config_data while a transaction is in HOLD (that data is a snapshot).
//  Clear (addr 17): all staging words <= 0 on the next edge; config_data is unaffected.
//  Clear overrun (addr 18): overrun <= 0.
//  Addresses 19..31: ignored.
//  FSM states: IDLE, HOLD, GAP.
//   IDLE: commit with s_wr_data != IDLE_ADDR, on the same edge:
//     config_addr <= s_wr_data; config_data <= staging; cnt <= HOLD_CYCLES-1;
//     commit_count++; -> HOLD.
//   IDLE: commit with s_wr_data == IDLE_ADDR: ignored; no count, no flag.
//   HOLD: cnt==0 -> config_addr <= IDLE_ADDR, -> GAP; else cnt--.
//     config_data holds its value.
//   GAP: exactly one cycle at IDLE_ADDR, then -> IDLE.
//     This guarantees that back-to-back commits to the same address form distinct transactions.
//   Commit in HOLD or GAP: dropped; overrun <= 1; commit_count unchanged.
//  Latency: commit strobe at edge N -> config_addr valid on cycles N+1..N+HOLD_CYCLES.
//   IDLE_ADDR is driven at N+HOLD_CYCLES+1. Minimum commit period is HOLD_CYCLES+2 cycles.
//  config_data retains the last committed snapshot after the transaction; receivers qualify on address only.
//  Widths: s_wr_addr compared unsigned. commit_count wraps at all-ones -> 0 without a flag.
// STRUCTURE
//  Shared package: localparams CFG_ADDR_W=32, CFG_DATA_W=512, CFG_WORDS=16.
//   Also holds the register-index constants (REG_COMMIT=16, REG_CLEAR=17, REG_CLR_OVR=18)
//   and the FSM state encoding.
//  One sub-module: cfg_stage_buffer (16x32 register file with word write, synchronous clear, and full 512b parallel read).
//  The FSM, counters and output registers live in the top module.
// TESTING
//  1 Stage word0=0x00654321, commit 2000 -> config_addr=2000 for 2 cycles, config_data[31:0]=0x00654321,
//    then 0 for >=1 cycle; commit_count=1; busy high for 3 cycles.
//  2 Commit 2000 and, 1 cycle later, write word0=0xDEADBEEF -> config_data[31:0] stays 0x00654321
//    throughout HOLD; the next commit carries 0xDEADBEEF.
//  3 Commits at cycles 0 and 2 (HOLD_CYCLES=2) -> second commit dropped, overrun=1, commit_count=1;
//    write addr 18 -> overrun=0; a commit at cycle 4 is accepted.
//  4 Assert a_rst during the first HOLD cycle -> next edge: config_addr=0, config_data=0, busy=0,
//    commit_count=0, and staging reads back as zero on the following commit.
//  5 Commit with data 0 -> no bus activity, count unchanged.
//    Clear staging (addr 17) then commit 2001 -> config_data=0.
//  6 Preset commit_count to 0xFFFF via 65535 commits (or force) -> one more commit gives 0x0000.
//    Drive with a receiver model: axis selector at 2000 latches word0 exactly once per commit.

Source files
------------

// File: rtl/config_bus_writer_pkg.sv
// Shared definitions for the configuration bus writer.
// Bus geometry, register map and FSM encoding.
package config_bus_writer_pkg;

  localparam int CFG_ADDR_W = 32;
  localparam int CFG_DATA_W = 512;
  localparam int CFG_WORDS  = 16;
  localparam int CFG_WORD_W = 32;

  localparam logic [4:0] REG_COMMIT  = 5'd16;
  localparam logic [4:0] REG_CLEAR   = 5'd17;
  localparam logic [4:0] REG_CLR_OVR = 5'd18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/config_bus_writer_stage.sv
// Staging register file: word write, synchronous clear,
// full-width parallel read for the commit snapshot.
module cfg_stage_buffer
  import config_bus_writer_pkg::*;
#(
  parameter int WORDS = CFG_WORDS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [$clog2(WORDS)-1:0]    wr_idx,
  input  logic [CFG_WORD_W-1:0]       wr_data,
  input  logic                        clr,
  output logic [WORDS*CFG_WORD_W-1:0] rd_data
);

  logic [WORDS*CFG_WORD_W-1:0] buf_q;
  logic [WORDS*CFG_WORD_W-1:0] buf_d;

  // Clear wins over a word write; both cannot arrive together.
  always_comb begin
    buf_d = buf_q;
    if (clr) begin
      buf_d = '0;
    end else if (wr_en) begin
      buf_d[wr_idx*CFG_WORD_W +: CFG_WORD_W] = wr_data;
    end
  end

  // Register file storage.
  always_ff @(posedge clk) begin
    if (rst) buf_q <= '0;
    else     buf_q <= buf_d;
  end

  assign rd_data = buf_q;

endmodule

// File: rtl/config_bus_writer.sv
// Config bus master: stages words, commits a snapshot,
// holds address+data, then one idle gap cycle.
module config_bus_writer
  import config_bus_writer_pkg::*;
#(
  parameter int                    DATA_WORDS  = CFG_WORDS,
  parameter int                    HOLD_CYCLES = 2,
  parameter logic [CFG_ADDR_W-1:0] IDLE_ADDR   = '0,
  parameter int                    COUNT_WIDTH = 16
) (
  input  logic                   a_clk,
  input  logic                   a_rst,
  input  logic                   s_wr_en,
  input  logic [4:0]             s_wr_addr,
  input  logic [31:0]            s_wr_data,
  output logic [CFG_ADDR_W-1:0]  config_addr,
  output logic [CFG_DATA_W-1:0]  config_data,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] commit_count,
  output logic                   overrun
);

  localparam int CNT_W =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(HOLD_CYCLES - 1);

  cfg_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CFG_ADDR_W-1:0]  addr_q, addr_d;
  logic [CFG_DATA_W-1:0]  data_q, data_d;
  logic                   busy_q, busy_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   ovr_q, ovr_d;

  logic                   stage_we;
  logic                   stage_clr;
  logic                   commit;
  logic [CFG_DATA_W-1:0]  stage_data;

  assign stage_we  = s_wr_en && (s_wr_addr < REG_COMMIT);
  assign stage_clr = s_wr_en && (s_wr_addr == REG_CLEAR);
  assign commit    = s_wr_en && (s_wr_addr == REG_COMMIT);

  cfg_stage_buffer #(
    .WORDS (DATA_WORDS)
  ) u_stage (
    .clk     (a_clk),
    .rst     (a_rst),
    .wr_en   (stage_we),
    .wr_idx  (s_wr_addr[3:0]),
    .wr_data (s_wr_data),
    .clr     (stage_clr),
    .rd_data (stage_data)
  );

  // Next-state: commit acceptance, hold countdown, gap, overrun.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    count_d = count_q;
    ovr_d   = ovr_q;
    if (s_wr_en && (s_wr_addr == REG_CLR_OVR)) ovr_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (commit && (s_wr_data != IDLE_ADDR)) begin
          addr_d  = s_wr_data;
          data_d  = stage_data;
          cnt_d   = CNT_LOAD;
          count_d = count_q + COUNT_WIDTH'(1);
          busy_d  = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (commit) ovr_d = 1'b1;
        if (cnt_q == '0) begin
          addr_d  = IDLE_ADDR;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (commit) ovr_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        addr_d  = IDLE_ADDR;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered bus outputs; reset aborts any transaction.
  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= IDLE_ADDR;
      data_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      ovr_q   <= ovr_d;
    end
  end

  assign config_addr  = addr_q;
  assign config_data  = data_q;
  assign busy         = busy_q;
  assign commit_count = count_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_config_bus_writer.sv
// Randomized bench for config_bus_writer against a
// timeline-based transaction model.
module tb_config_bus_writer;
  import config_bus_writer_pkg::*;

  localparam int H = 2;

  logic         a_clk = 1'b0;
  logic         a_rst;
  logic         s_wr_en;
  logic [4:0]   s_wr_addr;
  logic [31:0]  s_wr_data;

  logic [31:0]  config_addr;
  logic [511:0] config_data;
  logic         busy;
  logic [15:0]  commit_count;
  logic         overrun;

  logic [31:0]  w_addr;
  logic [511:0] w_data;
  logic         w_busy;
  logic [3:0]   w_count;
  logic         w_ovr;

  config_bus_writer dut (
    .a_clk        (a_clk),
    .a_rst        (a_rst),
    .s_wr_en      (s_wr_en),
    .s_wr_addr    (s_wr_addr),
    .s_wr_data    (s_wr_data),
    .config_addr  (config_addr),
    .config_data  (config_data),
    .busy         (busy),
    .commit_count (commit_count),
    .overrun      (overrun)
  );

  // Narrow counter instance so the wrap is reached quickly.
  config_bus_writer #(.COUNT_WIDTH(4)) dut_w (
    .a_clk        (a_clk),
    .a_rst        (a_rst),
    .s_wr_en      (s_wr_en),
    .s_wr_addr    (s_wr_addr),
    .s_wr_data    (s_wr_data),
    .config_addr  (w_addr),
    .config_data  (w_data),
    .busy         (w_busy),
    .commit_count (w_count),
    .overrun      (w_ovr)
  );

  always #4 a_clk = ~a_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [511:0] obs,
                       input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: staging words, last accepted commit time and payload.
  logic [31:0]  m_stage [16];
  logic [511:0] m_data;
  logic [31:0]  m_taddr;
  longint       n;
  longint       tc;
  bit           has_tc;
  int unsigned  m_count;
  bit           m_ovr;
  int           m_rx;

  // Receiver model: selector at 2000 latching word0 per transaction.
  int           rx_cnt;
  logic [31:0]  rx_word;
  logic [31:0]  prev_addr;

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_stage[k] = '0;
    m_data  = '0;
    m_taddr = '0;
    has_tc  = 0;
    m_count = 0;
    m_ovr   = 0;
  endtask

  task automatic step(input bit rst, input bit en,
                      input logic [4:0] a,
                      input logic [31:0] d);
    logic [31:0] e_addr;
    bit          e_busy;
    @(negedge a_clk);
    a_rst     = rst;
    s_wr_en   = en;
    s_wr_addr = a;
    s_wr_data = d;
    @(posedge a_clk);
    n++;
    if (rst) begin
      model_reset();
    end else if (en) begin
      if (a < 5'd16) begin
        m_stage[a[3:0]] = d;
      end else if (a == 5'd16) begin
        if (!has_tc || (n - 1 > tc + H)) begin
          if (d != 32'd0) begin
            tc      = n;
            has_tc  = 1;
            m_taddr = d;
            for (int k = 0; k < 16; k++)
              m_data[32*k +: 32] = m_stage[k];
            m_count++;
            if (d == 32'd2000) m_rx++;
          end
        end else begin
          m_ovr = 1;
        end
      end else if (a == 5'd17) begin
        for (int k = 0; k < 16; k++) m_stage[k] = '0;
      end else if (a == 5'd18) begin
        m_ovr = 0;
      end
    end
    e_addr = (has_tc && (n - tc < H)) ? m_taddr : 32'd0;
    e_busy = has_tc && (n - tc <= H);
    #1;
    check("config_addr", 512'(config_addr), 512'(e_addr));
    check("config_data", config_data, m_data);
    check("busy", 512'(busy), 512'(e_busy));
    check("commit_count", 512'(commit_count),
          512'(m_count[15:0]));
    check("overrun", 512'(overrun), 512'(m_ovr));
    check("count_wrap4", 512'(w_count), 512'(m_count[3:0]));
    if (config_addr == 32'd2000 && prev_addr != 32'd2000) begin
      rx_cnt++;
      rx_word = config_data[31:0];
    end
    prev_addr = config_addr;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 5'd0, 32'd0);
  endtask

  initial begin
    int r;
    logic [31:0] d;
    n = 0; tc = 0; m_rx = 0;
    rx_cnt = 0; rx_word = '0; prev_addr = '0;
    a_rst = 1; s_wr_en = 0; s_wr_addr = '0; s_wr_data = '0;
    model_reset();
    step(1, 0, 5'd0, 32'd0);
    step(1, 0, 5'd0, 32'd0);
    check("reset_addr", 512'(config_addr), 512'(0));
    check("reset_data", config_data, 512'(0));

    // Basic commit with word0 staged.
    step(0, 1, 5'd0, 32'h0065_4321);
    step(0, 1, 5'd16, 32'd2000);
    idle(4);
    check("rx_first", 512'(rx_word), 512'(32'h0065_4321));

    // Staging write during HOLD does not disturb the snapshot.
    step(0, 1, 5'd16, 32'd2000);
    step(0, 1, 5'd0, 32'hDEAD_BEEF);
    idle(2);
    step(0, 1, 5'd16, 32'd2000);
    idle(4);
    check("rx_snapshot", 512'(rx_word), 512'(32'hDEAD_BEEF));
    check("rx_count", 512'(rx_cnt), 512'(m_rx));

    // Overrun on early commit, cleared, then accepted.
    step(0, 1, 5'd16, 32'd3000);
    idle(1);
    step(0, 1, 5'd16, 32'd3001);
    step(0, 1, 5'd18, 32'd0);
    step(0, 1, 5'd16, 32'd3002);
    idle(4);

    // Reset in the first HOLD cycle.
    step(0, 1, 5'd16, 32'd2000);
    step(1, 0, 5'd0, 32'd0);
    idle(1);
    step(0, 1, 5'd16, 32'd2001);
    idle(4);

    // Commit to IDLE_ADDR ignored; clear then commit.
    step(0, 1, 5'd16, 32'd0);
    idle(1);
    step(0, 1, 5'd3, 32'h1234_5678);
    step(0, 1, 5'd17, 32'd0);
    step(0, 1, 5'd16, 32'd2001);
    idle(4);

    // Back-to-back commits to 2000 at minimum period.
    for (int i = 0; i < 18; i++) begin
      step(0, 1, 5'd0, 32'(i));
      step(0, 1, 5'd16, 32'd2000);
      idle(2);
    end
    idle(2);
    check("rx_b2b_count", 512'(rx_cnt), 512'(m_rx));
    check("rx_b2b_word", 512'(rx_word), 512'(32'd17));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      d = $urandom;
      if (r < 40) begin
        step(0, 1, 5'($urandom_range(0, 15)), d);
      end else if (r < 62) begin
        if ($urandom_range(0, 9) == 0) d = 32'd0;
        else if ($urandom_range(0, 2) == 0) d = 32'd2000;
        step(0, 1, 5'd16, d);
      end else if (r < 66) begin
        step(0, 1, 5'd17, d);
      end else if (r < 71) begin
        step(0, 1, 5'd18, d);
      end else if (r < 76) begin
        step(0, 1, 5'($urandom_range(19, 31)), d);
      end else if (r < 77) begin
        step(1, 1, 5'd16, d);
      end else begin
        step(0, 0, 5'($urandom_range(0, 31)), d);
      end
    end
    idle(4);
    check("rx_final_count", 512'(rx_cnt), 512'(m_rx));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
